pkt_len_server: RTL

- Consumer end of the packet-length generator interface: issues `go` to the length generator, accepts each offered `pkt_len`, and queues it.
- Queued packets are served one at a time: each takes its length in `cnt_clk` cycles.
- Provides the queue/service half of the FPQ queue experiments; occupancy and completion outputs feed the statistics benches.

---
 rtl/fpq_pkg.sv | 16 +
 rtl/pkt_len_server_if.sv | 13 +
 rtl/fpq_len_fifo.sv | 57 +++++
 rtl/pkt_len_server.sv | 132 +++++++++++++
 4 files changed

// File: rtl/fpq_pkg.sv
// Shared definitions for the FPQ queue blocks: service FSM encoding and default sizes.
package fpq_pkg;

  localparam int unsigned FPQ_DEPTH = 16;
  localparam int unsigned FPQ_LEN_W = 8;
  localparam int unsigned FPQ_CNT_W = 5;

  typedef logic [FPQ_LEN_W-1:0] fpq_len_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } svc_state_e;

endpackage

// File: rtl/pkt_len_server_if.sv
// Packet-length generator handshake: a transfer happens on an edge with pkt_vld && go.
interface pkt_len_server_if #(
  parameter int unsigned LEN_W = fpq_pkg::FPQ_LEN_W
);

  logic             pkt_vld;
  logic [LEN_W-1:0] pkt_len;
  logic             go;

  modport master (output pkt_vld, output pkt_len, input go);
  modport slave  (input pkt_vld, input pkt_len, output go);

endinterface

// File: rtl/fpq_len_fifo.sv
// DEPTH x LEN_W synchronous FIFO with show-ahead head, occupancy count and registered write-ready.
module fpq_len_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             cnt_clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [LEN_W-1:0] wdata_i,
  input  logic             rd_i,
  output logic [LEN_W-1:0] head_c_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             full_o,
  output logic             wr_rdy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, wr_rdy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_i && !rd_i)      cnt_d = cnt_q + CNT_W'(1);
    else if (!wr_i && rd_i) cnt_d = cnt_q - CNT_W'(1);
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
  always_ff @(posedge cnt_clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      wr_rdy_q <= 1'b1;
    end else begin
      if (wr_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == CNT_W'(DEPTH));
      wr_rdy_q <= (cnt_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge cnt_clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_c_o = mem_q[rd_ptr_q];
  assign cnt_o    = cnt_q;
  assign full_o   = full_q;
  assign wr_rdy_o = wr_rdy_q;

endmodule

// File: rtl/pkt_len_server.sv
// Queues offered packet lengths and serves them one at a time, one cycle per length unit.
// Optional statistics counters are built when PKT_SRV_STATS_EN is defined.
module pkt_len_server import fpq_pkg::*; #(
  parameter int unsigned DEPTH = FPQ_DEPTH,
  parameter int unsigned LEN_W = FPQ_LEN_W,
  parameter int unsigned CNT_W = FPQ_CNT_W
) (
  input  logic             cnt_clk,
  input  logic             rst_n,
  pkt_len_server_if.slave  gen,
  output logic             busy,
  output logic [LEN_W-1:0] svc_left,
  output logic [CNT_W-1:0] q_cnt,
  output logic             done,
  output logic             full
`ifdef PKT_SRV_STATS_EN
  ,
  output logic [15:0]      served_cnt,
  output logic [15:0]      zero_drop_cnt,
  output logic [31:0]      busy_cyc
`endif
);

  svc_state_e       state_q, state_d;
  logic [LEN_W-1:0] svc_q, svc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pop;
  logic             accept, wr;
  logic [LEN_W-1:0] head;
  logic             go_w;

  assign accept = gen.pkt_vld && go_w;
  assign wr     = accept && (gen.pkt_len != '0);

  fpq_len_fifo #(
    .DEPTH (DEPTH),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .cnt_clk  (cnt_clk),
    .rst_n    (rst_n),
    .wr_i     (wr),
    .wdata_i  (gen.pkt_len),
    .rd_i     (pop),
    .head_c_o (head),
    .cnt_o    (q_cnt),
    .full_o   (full),
    .wr_rdy_o (go_w)
  );

  always_ff @(posedge cnt_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      svc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // done is registered, so it is raised on the edge that makes svc_left equal 1.
  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (q_cnt != '0) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop     = 1'b1;
        svc_d   = head;
        busy_d  = 1'b1;
        done_d  = (head == LEN_W'(1));
        state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (svc_q <= LEN_W'(1)) begin
          svc_d   = '0;
          busy_d  = 1'b0;
          state_d = (q_cnt != '0) ? ST_LOAD : ST_IDLE;
        end else begin
          svc_d  = svc_q - LEN_W'(1);
          done_d = (svc_q == LEN_W'(2));
        end
      end
      default: begin
        state_d = ST_IDLE;
        svc_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gen.go   = go_w;
  assign busy     = busy_q;
  assign svc_left = svc_q;
  assign done     = done_q;

`ifdef PKT_SRV_STATS_EN
  logic [15:0] served_q, zdrop_q;
  logic [31:0] bcyc_q;
  logic        zero_drop;

  assign zero_drop = accept && (gen.pkt_len == '0);

  // Event counters saturate; the busy-cycle counter wraps.
  always_ff @(posedge cnt_clk) begin
    if (!rst_n) begin
      served_q <= '0;
      zdrop_q  <= '0;
      bcyc_q   <= '0;
    end else begin
      if (done_q && (served_q != 16'hFFFF))   served_q <= served_q + 16'd1;
      if (zero_drop && (zdrop_q != 16'hFFFF)) zdrop_q  <= zdrop_q + 16'd1;
      if (busy_q)                             bcyc_q   <= bcyc_q + 32'd1;
    end
  end

  assign served_cnt    = served_q;
  assign zero_drop_cnt = zdrop_q;
  assign busy_cyc      = bcyc_q;
`endif

endmodule
